cla_seq_adder: RTL



---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_slice.sv | 47 ++++
 rtl/cla_seq_adder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder:
// FSM state encoding, default slice width and index-width helper.
package cla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int SLICE_DEF = 5;

   // Width of a counter that indexes n slices; never narrower than 1 bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead slice.
// Every carry is formed directly from propagate/generate terms and the
// slice carry-in, so no carry ripples through the slice itself.
module cla_slice #(
   parameter int SLICE = 5
)(
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             c_in,
   output logic [SLICE-1:0] s,
   output logic             c_out,
   output logic             c_msb
);

   logic [SLICE-1:0] p;
   logic [SLICE-1:0] g;
   logic [SLICE:0]   c;

   assign p = a ^ b;
   assign g = a & b;

   // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in.
   always_comb begin
      logic term;
      logic acc;
      c    = '0;
      term = 1'b0;
      acc  = 1'b0;
      c[0] = c_in;
      for (int i = 0; i < SLICE; i++) begin
         term = c_in;
         for (int j = 0; j <= i; j++) term = term & p[j];
         acc = term;
         for (int k = 0; k <= i; k++) begin
            term = g[k];
            for (int j = k + 1; j <= i; j++) term = term & p[j];
            acc = acc | term;
         end
         c[i+1] = acc;
      end
   end

   assign s     = p ^ c[SLICE-1:0];
   assign c_out = c[SLICE];
   assign c_msb = c[SLICE-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one SLICE-bit lookahead slice,
// one slice per cycle, carrying between slices through a register.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE, out_valid only in DONE; sum/cout (and ovf)
// stay stable while out_valid is high and out_ready is low.
module cla_seq_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int SLICE = SLICE_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef CLA_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = idx_width(NSLICE);

   if (WIDTH % SLICE != 0) begin : g_width_check
      $error("cla_seq_adder: WIDTH must be an integer multiple of SLICE");
   end

   state_e           state;
   state_e           state_n;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IW-1:0]    idx;
   logic             accept;
   logic             last;
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_s;
   logic             slice_cout;
   logic             slice_msb;

   assign accept  = (state == IDLE) && in_valid;
   assign last    = (state == RUN) && (idx == IW'(NSLICE - 1));
   assign slice_a = a_q[int'(idx)*SLICE +: SLICE];
   assign slice_b = b_q[int'(idx)*SLICE +: SLICE];

   cla_slice #(.SLICE(SLICE)) u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .c_in  (carry_q),
      .s     (slice_s),
      .c_out (slice_cout),
      .c_msb (slice_msb)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state: accept in IDLE, step through slices, hold until taken.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid)  state_n = RUN;
         RUN:     if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == RUN);
   assign out_valid = (state == DONE);

   // Operand capture, slice stepping and result accumulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= cin;
         idx     <= '0;
      end else if (state == RUN) begin
         sum[int'(idx)*SLICE +: SLICE] <= slice_s;
         carry_q                       <= slice_cout;
         if (last) cout <= slice_cout;
         else      idx  <= idx + 1'b1;
      end
   end

`ifdef CLA_SEQ_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       ovf <= 1'b0;
      else if (last) ovf <= slice_msb ^ slice_cout;
   end
`else
   logic unused_msb;
   assign unused_msb = slice_msb;
`endif

endmodule
